// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants and types for the sprite drawer and mask logic.
package chip8_pkg;

    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 32;
    localparam int SPRITE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_CHECK,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_FB_REQ,
        ST_FB_WAIT,
        ST_FB_WRITE,
        ST_DONE
    } drawer_state_t;

    typedef logic [SCREEN_W-1:0] fb_row_t;

endpackage

// File: rtl/chip8_sprite_mask.sv
// Places one 8-pixel sprite byte onto a 64-column row mask, either clipping or
// wrapping pixels that run past the right edge.
module chip8_sprite_mask
    import chip8_pkg::*;
(
    input  logic [SPRITE_W-1:0] sprite_i,
    input  logic [5:0]          x0_i,
    input  logic                clip_i,
    output fb_row_t             mask_o
);

    logic [6:0] col;

    always_comb begin
        mask_o = '0;
        col    = '0;
        for (int k = 0; k < SPRITE_W; k++) begin
            col = {1'b0, x0_i} + 7'(k);
            // The MSB of the byte is the leftmost pixel; col[5:0] is the wrapped column.
            if (sprite_i[SPRITE_W-1-k] && (!col[6] || !clip_i)) begin
                mask_o[col[5:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DXYN engine: fetches sprite bytes, XORs them into framebuffer rows via
// read-modify-write, and reports the VF collision flag.
module chip8_sprite_drawer
    import chip8_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int FB_LATENCY  = 2,
    parameter bit CLIP        = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        draw_valid_in,
    output logic        draw_ready_out,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] i_in,
    output logic [11:0] mem_addr_out,
    output logic        mem_en_out,
    input  logic [7:0]  mem_data_in,
    output logic [4:0]  fb_addr_out,
    output logic        fb_rd_en_out,
    input  fb_row_t     fb_row_in,
    output logic        fb_we_out,
    output fb_row_t     fb_row_out,
    output logic        done_out,
    output logic        collision_out
);

    drawer_state_t state_q, state_d;
    logic [5:0]    x0_q, x0_d;
    logic [4:0]    y0_q, y0_d;
    logic [3:0]    n_q, n_d;
    logic [11:0]   base_q, base_d;
    logic [3:0]    r_q, r_d;
    logic [7:0]    wait_q, wait_d;
    logic [7:0]    sprite_q, sprite_d;
    logic          coll_q, coll_d;
    logic [11:0]   mem_addr_q, mem_addr_d;
    logic [4:0]    fb_addr_q, fb_addr_d;

    logic [5:0]    row_sum;
    fb_row_t       mask;

    assign row_sum = {1'b0, y0_q} + {2'b00, r_q};

    chip8_sprite_mask u_mask (
        .sprite_i (sprite_q),
        .x0_i     (x0_q),
        .clip_i   (CLIP),
        .mask_o   (mask)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            n_q        <= '0;
            base_q     <= '0;
            r_q        <= '0;
            wait_q     <= '0;
            sprite_q   <= '0;
            coll_q     <= 1'b0;
            mem_addr_q <= '0;
            fb_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            n_q        <= n_d;
            base_q     <= base_d;
            r_q        <= r_d;
            wait_q     <= wait_d;
            sprite_q   <= sprite_d;
            coll_q     <= coll_d;
            mem_addr_q <= mem_addr_d;
            fb_addr_q  <= fb_addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        x0_d           = x0_q;
        y0_d           = y0_q;
        n_d            = n_q;
        base_d         = base_q;
        r_d            = r_q;
        wait_d         = wait_q;
        sprite_d       = sprite_q;
        coll_d         = coll_q;
        mem_addr_d     = mem_addr_q;
        fb_addr_d      = fb_addr_q;
        draw_ready_out = 1'b0;
        mem_en_out     = 1'b0;
        fb_rd_en_out   = 1'b0;
        fb_we_out      = 1'b0;
        fb_row_out     = '0;
        done_out       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                draw_ready_out = 1'b1;
                if (draw_valid_in) begin
                    x0_d    = x_in[5:0];
                    y0_d    = y_in[4:0];
                    n_d     = n_in;
                    base_d  = i_in;
                    r_d     = '0;
                    coll_d  = 1'b0;
                    state_d = ST_ROW_CHECK;
                end
            end
            ST_ROW_CHECK: begin
                // Rows only move downward, so the first off-screen row ends the draw.
                if (r_q == n_q || (CLIP && row_sum[5])) begin
                    state_d = ST_DONE;
                end else begin
                    mem_addr_d = base_q + {8'd0, r_q};
                    state_d    = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                mem_en_out = 1'b1;
                wait_d     = '0;
                state_d    = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (wait_q == 8'(MEM_LATENCY - 1)) begin
                    sprite_d  = mem_data_in;
                    fb_addr_d = row_sum[4:0];
                    wait_d    = '0;
                    state_d   = ST_FB_REQ;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_FB_REQ: begin
                fb_rd_en_out = 1'b1;
                wait_d       = '0;
                state_d      = (FB_LATENCY > 1) ? ST_FB_WAIT : ST_FB_WRITE;
            end
            ST_FB_WAIT: begin
                if (wait_q == 8'(FB_LATENCY - 2)) begin
                    state_d = ST_FB_WRITE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_FB_WRITE: begin
                // Row data arrives exactly this cycle and is merged straight through.
                fb_we_out  = 1'b1;
                fb_row_out = fb_row_in ^ mask;
                coll_d     = coll_q | (|(fb_row_in & mask));
                r_d        = r_q + 4'd1;
                state_d    = ST_ROW_CHECK;
            end
            ST_DONE: begin
                done_out   = 1'b1;
                mem_addr_d = '0;
                fb_addr_d  = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr_out  = mem_addr_q;
    assign fb_addr_out   = fb_addr_q;
    assign collision_out = coll_q;

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Bench for chip8_sprite_drawer: a clipping and a wrapping instance share stimulus,
// each with its own framebuffer RAM, checked against a pixel-level draw model.
module tb_chip8_sprite_drawer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid;
    logic [7:0]  x, y;
    logic [3:0]  n;
    logic [11:0] ib;

    logic        ready [2];
    logic [11:0] maddr [2];
    logic        men   [2];
    logic [7:0]  mdat  [2];
    logic [4:0]  faddr [2];
    logic        frd   [2];
    logic [63:0] frin  [2];
    logic        fwe   [2];
    logic [63:0] frout [2];
    logic        done  [2];
    logic        coll  [2];

    chip8_sprite_drawer #(.MEM_LATENCY(2), .FB_LATENCY(2), .CLIP(1'b1)) u_clip (
        .clk_in(clk), .rst_in(rst_n), .draw_valid_in(valid), .draw_ready_out(ready[0]),
        .x_in(x), .y_in(y), .n_in(n), .i_in(ib),
        .mem_addr_out(maddr[0]), .mem_en_out(men[0]), .mem_data_in(mdat[0]),
        .fb_addr_out(faddr[0]), .fb_rd_en_out(frd[0]), .fb_row_in(frin[0]),
        .fb_we_out(fwe[0]), .fb_row_out(frout[0]), .done_out(done[0]), .collision_out(coll[0]));

    chip8_sprite_drawer #(.MEM_LATENCY(2), .FB_LATENCY(2), .CLIP(1'b0)) u_wrap (
        .clk_in(clk), .rst_in(rst_n), .draw_valid_in(valid), .draw_ready_out(ready[1]),
        .x_in(x), .y_in(y), .n_in(n), .i_in(ib),
        .mem_addr_out(maddr[1]), .mem_en_out(men[1]), .mem_data_in(mdat[1]),
        .fb_addr_out(faddr[1]), .fb_rd_en_out(frd[1]), .fb_row_in(frin[1]),
        .fb_we_out(fwe[1]), .fb_row_out(frout[1]), .done_out(done[1]), .collision_out(coll[1]));

    // Fixed-latency memory and framebuffer RAMs (two-cycle address pipeline).
    logic [7:0]  mem [4096];
    logic [63:0] fbram [2][32];
    logic [11:0] ma0 [2], ma1 [2];
    logic [4:0]  fa0 [2], fa1 [2];
    logic        fb_clr;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int j = 0; j < 2; j++) begin
            ma1[j] <= ma0[j];
            ma0[j] <= maddr[j];
            fa1[j] <= fa0[j];
            fa0[j] <= faddr[j];
            if (fb_clr) begin
                for (int k = 0; k < 32; k++) fbram[j][k] <= '0;
            end else if (fwe[j]) begin
                fbram[j][faddr[j]] <= frout[j];
            end
        end
    end

    assign mdat[0] = mem[ma1[0]];
    assign mdat[1] = mem[ma1[1]];
    assign frin[0] = fbram[0][fa1[0]];
    assign frin[1] = fbram[1][fa1[1]];

    // Model state and scoreboard (index 0 = clipping, 1 = wrapping).
    logic [63:0] mfb    [2][32];
    logic [11:0] exp_ma [2][16];
    logic [4:0]  exp_fa [2][16];
    logic [63:0] exp_fd [2][16];
    int          exp_rows [2];
    logic        exp_coll [2];
    int          seen_m [2], seen_r [2], seen_w [2];
    bit          active [2];
    int          acc_cyc;
    int          last_lat [2], last_nmem [2];
    logic        last_coll [2];
    int          passed = 0, total = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, expv, $time);
    endtask

    task automatic model(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                         input logic [11:0] ii);
        for (int j = 0; j < 2; j++) begin
            int x0;
            int y0;
            bit clip;
            x0 = int'(xx) % 64;
            y0 = int'(yy) % 32;
            clip = (j == 0);
            exp_rows[j] = 0;
            exp_coll[j] = 1'b0;
            for (int r = 0; r < int'(nn); r++) begin
                int row;
                int yr;
                logic [7:0]  b;
                logic [63:0] m;
                yr = y0 + r;
                if (clip && yr >= 32) break;
                row = yr % 32;
                b = mem[(int'(ii) + r) % 4096];
                m = '0;
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = x0 + k;
                    if (b[7-k]) begin
                        if (c < 64) m[c] = 1'b1;
                        else if (!clip) m[c-64] = 1'b1;
                    end
                end
                if ((mfb[j][row] & m) != 64'd0) exp_coll[j] = 1'b1;
                mfb[j][row] = mfb[j][row] ^ m;
                exp_ma[j][r] = 12'((int'(ii) + r) % 4096);
                exp_fa[j][r] = 5'(row);
                exp_fd[j][r] = mfb[j][row];
                exp_rows[j]++;
            end
        end
    endtask

    task automatic monitor();
        for (int j = 0; j < 2; j++) begin
            if (!active[j]) begin
                chk("idle_outputs",
                    128'({ready[j], men[j], frd[j], fwe[j], done[j], maddr[j], faddr[j], frout[j]}),
                    128'({1'b1, 85'd0}));
            end else begin
                chk("strobe_onehot", 128'($countones({men[j], frd[j], fwe[j]}) <= 1), 128'(1));
                if (men[j]) begin
                    if (seen_m[j] < exp_rows[j]) chk("mem_addr", 128'(maddr[j]), 128'(exp_ma[j][seen_m[j]]));
                    else chk("mem_extra_read", 128'(maddr[j]), 128'('1));
                    seen_m[j]++;
                end
                if (frd[j]) begin
                    if (seen_r[j] < exp_rows[j]) chk("fb_rd_addr", 128'(faddr[j]), 128'(exp_fa[j][seen_r[j]]));
                    else chk("fb_extra_read", 128'(faddr[j]), 128'('1));
                    seen_r[j]++;
                end
                if (fwe[j]) begin
                    if (seen_w[j] < exp_rows[j]) begin
                        chk("fb_wr_addr", 128'(faddr[j]), 128'(exp_fa[j][seen_w[j]]));
                        chk("fb_wr_data", 128'(frout[j]), 128'(exp_fd[j][seen_w[j]]));
                    end else chk("fb_extra_write", 128'(faddr[j]), 128'('1));
                    seen_w[j]++;
                end
                if (done[j]) begin
                    chk("done_latency", 128'(cyc - acc_cyc), 128'(2 + 7 * exp_rows[j]));
                    chk("collision", 128'(coll[j]), 128'(exp_coll[j]));
                    chk("mem_read_count", 128'(seen_m[j]), 128'(exp_rows[j]));
                    chk("fb_write_count", 128'(seen_w[j]), 128'(exp_rows[j]));
                    last_lat[j]  = cyc - acc_cyc;
                    last_coll[j] = coll[j];
                    last_nmem[j] = seen_m[j];
                    active[j]    = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic clear_fb();
        fb_clr = 1'b1;
        tick();
        fb_clr = 1'b0;
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 32; k++) mfb[j][k] = '0;
    endtask

    task automatic draw(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                        input logic [11:0] ii, input int abort_at, input bit junk);
        model(xx, yy, nn, ii);
        x = xx; y = yy; n = nn; ib = ii; valid = 1'b1;
        acc_cyc = cyc;
        for (int j = 0; j < 2; j++) begin
            active[j] = 1'b1; seen_m[j] = 0; seen_r[j] = 0; seen_w[j] = 0;
        end
        tick();
        valid = 1'b0;
        for (int t = 0; t < 300 && (active[0] || active[1]); t++) begin
            if (abort_at > 0 && cyc - acc_cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                active[0] = 1'b0;
                active[1] = 1'b0;
                monitor();
                tick();
                rst_n = 1'b1;
            end
            if (junk && t == 8) begin
                valid = 1'b1; x = 8'h10; y = 8'h10; n = 4'd1; ib = 12'h200;
            end
            if (junk && t == 10) valid = 1'b0;
            tick();
        end
        if (active[0] || active[1]) begin
            chk("draw_timeout", 128'(0), 128'(1));
            active[0] = 1'b0;
            active[1] = 1'b0;
        end
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; x = '0; y = '0; n = '0; ib = '0; fb_clr = 1'b0;
        active[0] = 1'b0; active[1] = 1'b0;
        for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
        mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
        mem[12'h100] = 8'hFF;
        mem[12'hFFF] = 8'h81;
        repeat (2) tick();
        for (int j = 0; j < 2; j++) chk("reset_collision", 128'(coll[j]), 128'(0));
        rst_n = 1'b1;
        tick();
        clear_fb();

        // Font glyph "0" on a blank screen, with a request arriving mid-draw.
        draw(8'd0, 8'd0, 4'd5, 12'h000, 0, 1'b1);
        chk("model_font_row1", 128'(mfb[0][1]), 128'(64'h09));
        for (int j = 0; j < 2; j++) begin
            chk("font_row0", 128'(fbram[j][0]), 128'(64'h0F));
            chk("font_row1", 128'(fbram[j][1]), 128'(64'h09));
            chk("font_row4", 128'(fbram[j][4]), 128'(64'h0F));
            chk("font_row5_blank", 128'(fbram[j][5]), 128'(64'h0));
            chk("font_latency", 128'(last_lat[j]), 128'(37));
            chk("font_collision", 128'(last_coll[j]), 128'(0));
        end

        // Redraw erases and collides.
        draw(8'd0, 8'd0, 4'd5, 12'h000, 0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            chk("redraw_row0", 128'(fbram[j][0]), 128'(0));
            chk("redraw_row3", 128'(fbram[j][3]), 128'(0));
            chk("redraw_collision", 128'(last_coll[j]), 128'(1));
        end

        // Right edge: clipped vs wrapped.
        clear_fb();
        draw(8'd60, 8'd0, 4'd1, 12'h100, 0, 1'b0);
        chk("right_clip", 128'(fbram[0][0]), 128'(64'hF000_0000_0000_0000));
        chk("right_wrap", 128'(fbram[1][0]), 128'(64'hF000_0000_0000_000F));

        // Bottom edge with sprite address wrap.
        clear_fb();
        draw(8'd0, 8'd31, 4'd3, 12'hFFF, 0, 1'b0);
        chk("bottom_clip_reads", 128'(last_nmem[0]), 128'(1));
        chk("bottom_wrap_reads", 128'(last_nmem[1]), 128'(3));
        chk("bottom_clip_row31", 128'(fbram[0][31]), 128'(64'h81));
        chk("bottom_clip_row0", 128'(fbram[0][0]), 128'(0));
        chk("bottom_wrap_row0", 128'(fbram[1][0]), 128'(64'h0F));
        chk("bottom_wrap_row1", 128'(fbram[1][1]), 128'(64'h09));
        chk("bottom_clip_latency", 128'(last_lat[0]), 128'(9));

        // Coordinates reduced modulo screen size.
        clear_fb();
        draw(8'h45, 8'h22, 4'd1, 12'h000, 0, 1'b0);
        for (int j = 0; j < 2; j++) chk("modulo_row2", 128'(fbram[j][2]), 128'(64'h1E0));

        // Zero-height sprite.
        draw(8'd3, 8'd3, 4'd0, 12'h000, 0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            chk("n0_latency", 128'(last_lat[j]), 128'(2));
            chk("n0_collision", 128'(last_coll[j]), 128'(0));
            chk("n0_reads", 128'(last_nmem[j]), 128'(0));
        end

        // Reset during FB_WAIT of row 2.
        clear_fb();
        draw(8'd0, 8'd8, 4'd4, 12'h000, 20, 1'b0);
        for (int j = 0; j < 2; j++) begin
            chk("abort_row8", 128'(fbram[j][8]), 128'(64'h0F));
            chk("abort_row9", 128'(fbram[j][9]), 128'(64'h09));
            chk("abort_row10", 128'(fbram[j][10]), 128'(0));
            chk("abort_collision", 128'(coll[j]), 128'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/chip8_sprite_drawer.md
Name: chip8_sprite_drawer

Overview:
- Executes the CHIP-8 DXYN draw as a memory-port initiator.
- Reads N sprite bytes from chip8 memory starting at I, and read-modify-writes 64-bit framebuffer rows with XOR.
- Returns the VF collision flag.
- Sits between the processor's execute stage and the chip8 memory / framebuffer RAM ports, which both have fixed read latency.

Parameters:
- MEM_LATENCY, 2, cycles from mem_en_out to valid mem_data_in.
- FB_LATENCY, 2, cycles from fb_rd_en_out to valid fb_row_in.
- CLIP, 1, 1 = pixels past the right or bottom edge are dropped; 0 = they wrap modulo 64/32.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- draw_valid_in  input  1  draw request
- draw_ready_out  output  1  high only in IDLE
- x_in  input  8  Vx value
- y_in  input  8  Vy value
- n_in  input  4  sprite height in rows
- i_in  input  12  sprite base address
- mem_addr_out  output  12  sprite byte address
- mem_en_out  output  1  memory read enable, 1-cycle pulse
- mem_data_in  input  8  sprite byte
- fb_addr_out  output  5  framebuffer row index
- fb_rd_en_out  output  1  framebuffer read pulse
- fb_row_in  input  64  row read data; bit c = column c
- fb_we_out  output  1  framebuffer write pulse
- fb_row_out  output  64  row write data
- done_out  output  1  1-cycle completion pulse
- collision_out  output  1  VF result; valid with done_out, held until next accept

Behaviour:
- Reset: state IDLE. Every output is 0 except draw_ready_out = 1. Counters are cleared.
- Reset asserted mid-operation aborts immediately. No partial write completes after reset; rows already written stay written.
- Accept: when draw_valid_in && draw_ready_out on a rising edge, latch:
  - x0 = x_in[5:0], y0 = y_in[4:0]
  - n = n_in, base = i_in
  - row counter r = 0, collision = 0
- Requests while busy are ignored; there is no queueing.
- States: IDLE -> ROW_CHECK -> MEM_REQ -> MEM_WAIT -> FB_REQ -> FB_WAIT -> FB_WRITE -> ROW_CHECK ... -> DONE -> IDLE.
- ROW_CHECK:
  - if r == n, go to DONE;
  - else if CLIP and y0+r >= 32, go to DONE (all remaining rows are also off-screen);
  - else go to MEM_REQ.
- MEM_REQ: mem_en_out = 1, mem_addr_out = (base + r) mod 4096 (12-bit wrap).
- MEM_WAIT: counts MEM_LATENCY-1 cycles, then captures mem_data_in into the sprite byte.
- FB_REQ: fb_rd_en_out = 1, fb_addr_out = (y0 + r) mod 32.
- FB_WAIT: counts FB_LATENCY-1 cycles, then captures fb_row_in.
- Mask: for k in 0..7, column c = x0 + k.
  - If c < 64, mask[c] = byte[7-k].
  - Otherwise, with CLIP=1 the bit is dropped; with CLIP=0, mask[c-64] = byte[7-k].
- FB_WRITE:
  - fb_we_out = 1, fb_addr_out = same row, fb_row_out = row ^ mask;
  - collision |= |(row & mask);
  - r++.
- DONE: done_out = 1, collision_out = collision, then IDLE.
- n = 0: accept -> ROW_CHECK -> DONE. No memory or framebuffer traffic; collision_out = 0.
- Per-row cost: 3 + MEM_LATENCY + FB_LATENCY cycles (7 at defaults). Total = 1 + rows*(3+MEM_LATENCY+FB_LATENCY) + 1.
- Strobes: at most one of mem_en_out, fb_rd_en_out, fb_we_out is high per cycle. Each is a single-cycle pulse.
- Address outputs are held stable between pulses. They return to 0 in IDLE.
- Only 8 columns are ever touched per row. All other bits of fb_row_out equal fb_row_in.

Decomposition:
- Shared package chip8_pkg holds:
  - SCREEN_W = 64, SCREEN_H = 32, SPRITE_W = 8;
  - drawer_state_t enum;
  - fb_row_t (logic [63:0]).
- One sub-module: chip8_sprite_mask, combinational. Inputs: byte, x0, CLIP. Output: 64-bit mask. It is reused by the later XOR/clear logic.

Test Plan:
- Font draw: i=0x000, mem[0..4] = F0 90 90 90 F0, x=0, y=0, n=5, blank fb.
  - rows 0..4 = 0x0F, 0x09, 0x09, 0x09, 0x0F in bits 0..7 (bit0 = col0 ← byte bit7);
  - collision_out = 0;
  - done_out at cycle 37 after accept.
- Redraw: same sprite drawn twice.
  - rows 0..4 return to 0;
  - collision_out = 1.
- Right-edge clip: x=60, y=0, n=1, byte=FF.
  - CLIP=1: bits 60..63 set only, bits 0..3 untouched.
  - CLIP=0: bits 60..63 and 0..3 set.
- Bottom clip plus address wrap: i=0xFFF, y=31, n=3, CLIP=1.
  - exactly one mem read at 0xFFF;
  - one fb write to row 31;
  - done, with no access to row 0.
  - With CLIP=0: reads 0xFFF, 0x000, 0x001; writes rows 31, 0, 1.
- Coordinate modulo: x=0x45, y=0x22.
  - treated as x0=5, y0=2.
- n=0, and mid-operation reset:
  - n=0: no strobes; done_out 2 cycles after accept; collision_out = 0.
  - rst_in low during FB_WAIT of row 2: all outputs 0 and draw_ready_out = 1 within the reset cycle; no fb_we_out thereafter; rows 0..1 stay written.
